// File: rtl/key_conditioner.sv
// Turns held key levels into registered one-cycle strobes: DAS/ARR for left/right,
// fixed-rate repeat for soft drop, and single shots for rotate, hard drop and hold.
module key_conditioner #(
  parameter int DAS_CYCLES  = 16_000_000,
  parameter int ARR_CYCLES  = 5_000_000,
  parameter int SOFT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic lvl_left,
  input  logic lvl_right,
  input  logic lvl_down,
  input  logic lvl_rotate_cw,
  input  logic lvl_rotate_ccw,
  input  logic lvl_drop,
  input  logic lvl_hold,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate_cw,
  output logic key_rotate_ccw,
  output logic key_drop,
  output logic key_hold,
  output logic key_drop_held
);

  localparam int HMAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int DW   = $clog2(SOFT_CYCLES + 1);

  localparam logic [HW-1:0] DAS_LAST  = HW'(DAS_CYCLES - 1);
  localparam logic [HW-1:0] ARR_LAST  = HW'(ARR_CYCLES - 1);
  localparam logic [DW-1:0] SOFT_LAST = DW'(SOFT_CYCLES - 1);

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_DAS  = 2'd1,
    H_ARR  = 2'd2
  } h_state_e;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_REP  = 1'b1
  } d_state_e;

  // Bit order: hold, drop, ccw, cw, down, right, left
  logic [6:0] lvl_vec;
  logic [6:0] rise;
  logic [6:0] prev_q, prev_d;

  h_state_e      h_state_q, h_state_d;
  logic          dir_q, dir_d;            // 0 = left, 1 = right
  logic [HW-1:0] hcnt_q, hcnt_d;
  d_state_e      d_state_q, d_state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic key_left_q, key_left_d;
  logic key_right_q, key_right_d;
  logic key_down_q, key_down_d;
  logic key_rotate_cw_q, key_rotate_cw_d;
  logic key_rotate_ccw_q, key_rotate_ccw_d;
  logic key_drop_q, key_drop_d;
  logic key_hold_q, key_hold_d;
  logic key_drop_held_q, key_drop_held_d;

  logic          h_fire;
  logic          opp_rise;
  logic          act_lvl;
  logic          opp_lvl;
  logic [HW-1:0] h_last;

  assign lvl_vec = {lvl_hold, lvl_drop, lvl_rotate_ccw, lvl_rotate_cw,
                    lvl_down, lvl_right, lvl_left};
  assign rise    = lvl_vec & ~prev_q;

  always_comb begin
    prev_d           = lvl_vec;
    h_state_d        = h_state_q;
    dir_d            = dir_q;
    hcnt_d           = hcnt_q;
    d_state_d        = d_state_q;
    dcnt_d           = dcnt_q;
    h_fire           = 1'b0;
    opp_rise         = dir_q ? rise[0] : rise[1];
    act_lvl          = dir_q ? lvl_right : lvl_left;
    opp_lvl          = dir_q ? lvl_left : lvl_right;
    h_last           = (h_state_q == H_DAS) ? DAS_LAST : ARR_LAST;
    key_down_d       = 1'b0;
    key_rotate_cw_d  = rise[3];
    key_rotate_ccw_d = rise[4] & ~rise[3];
    key_drop_d       = rise[5];
    key_hold_d       = rise[6];
    key_drop_held_d  = lvl_drop;

    case (h_state_q)
      H_IDLE: begin
        if (rise[0] || rise[1]) begin
          h_fire    = 1'b1;
          dir_d     = ~rise[0];
          hcnt_d    = '0;
          h_state_d = H_DAS;
        end
      end
      H_DAS, H_ARR: begin
        // The opposite key takes over on its own press, or when it is
        // still held as the active key lets go.
        if (opp_rise || (!act_lvl && opp_lvl)) begin
          h_fire    = 1'b1;
          dir_d     = ~dir_q;
          hcnt_d    = '0;
          h_state_d = H_DAS;
        end else if (!act_lvl) begin
          hcnt_d    = '0;
          h_state_d = H_IDLE;
        end else if (hcnt_q == h_last) begin
          h_fire    = 1'b1;
          hcnt_d    = '0;
          h_state_d = H_ARR;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        hcnt_d    = '0;
        h_state_d = H_IDLE;
      end
    endcase

    case (d_state_q)
      D_IDLE: begin
        if (rise[2]) begin
          key_down_d = 1'b1;
          dcnt_d     = '0;
          d_state_d  = D_REP;
        end
      end
      D_REP: begin
        if (!lvl_down) begin
          dcnt_d    = '0;
          d_state_d = D_IDLE;
        end else if (dcnt_q == SOFT_LAST) begin
          key_down_d = 1'b1;
          dcnt_d     = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        dcnt_d    = '0;
        d_state_d = D_IDLE;
      end
    endcase

    key_left_d  = h_fire & ~dir_d;
    key_right_d = h_fire & dir_d;

    // Paused: silence everything and park both FSMs, but prev_d still tracks.
    if (!enable) begin
      h_state_d        = H_IDLE;
      dir_d            = 1'b0;
      hcnt_d           = '0;
      d_state_d        = D_IDLE;
      dcnt_d           = '0;
      key_left_d       = 1'b0;
      key_right_d      = 1'b0;
      key_down_d       = 1'b0;
      key_rotate_cw_d  = 1'b0;
      key_rotate_ccw_d = 1'b0;
      key_drop_d       = 1'b0;
      key_hold_d       = 1'b0;
      key_drop_held_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q           <= '1;
      h_state_q        <= H_IDLE;
      dir_q            <= 1'b0;
      hcnt_q           <= '0;
      d_state_q        <= D_IDLE;
      dcnt_q           <= '0;
      key_left_q       <= 1'b0;
      key_right_q      <= 1'b0;
      key_down_q       <= 1'b0;
      key_rotate_cw_q  <= 1'b0;
      key_rotate_ccw_q <= 1'b0;
      key_drop_q       <= 1'b0;
      key_hold_q       <= 1'b0;
      key_drop_held_q  <= 1'b0;
    end else begin
      prev_q           <= prev_d;
      h_state_q        <= h_state_d;
      dir_q            <= dir_d;
      hcnt_q           <= hcnt_d;
      d_state_q        <= d_state_d;
      dcnt_q           <= dcnt_d;
      key_left_q       <= key_left_d;
      key_right_q      <= key_right_d;
      key_down_q       <= key_down_d;
      key_rotate_cw_q  <= key_rotate_cw_d;
      key_rotate_ccw_q <= key_rotate_ccw_d;
      key_drop_q       <= key_drop_d;
      key_hold_q       <= key_hold_d;
      key_drop_held_q  <= key_drop_held_d;
    end
  end

  assign key_left       = key_left_q;
  assign key_right      = key_right_q;
  assign key_down       = key_down_q;
  assign key_rotate_cw  = key_rotate_cw_q;
  assign key_rotate_ccw = key_rotate_ccw_q;
  assign key_drop       = key_drop_q;
  assign key_hold       = key_hold_q;
  assign key_drop_held  = key_drop_held_q;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Turns raw held-key levels from the keyboard decoder into the single-cycle move/rotate/drop/hold strobes and the `key_drop_held` level that `game_control` consumes. Left/right get delayed auto-shift (DAS) followed by auto-repeat (ARR). Soft drop repeats at a fixed rate. Rotate, hard drop and hold fire once per press. It sits between the PS/2 scancode decoder and `game_control`, in the game clock domain.

## Interface
- `DAS_CYCLES`, default 16_000_000: cycles from the initial left/right pulse to the first repeat; ≥1.
- `ARR_CYCLES`, default 5_000_000: cycles between left/right repeats after DAS; ≥1.
- `SOFT_CYCLES`, default 5_000_000: cycles between soft-drop repeats; ≥1.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  game running; low when paused or game over.
- `lvl_left`, `lvl_right`, `lvl_down`  in  1 each  held levels, already synchronized.
- `lvl_rotate_cw`, `lvl_rotate_ccw`, `lvl_drop`, `lvl_hold`  in  1 each  held levels, already synchronized.
- `key_left`, `key_right`, `key_down`  out  1 each  one-cycle move strobes.
- `key_rotate_cw`, `key_rotate_ccw`, `key_drop`, `key_hold`  out  1 each  one-cycle strobes.
- `key_drop_held`  out  1  registered copy of `lvl_drop`, gated by `enable`.

## Operation
- **Registered outputs.** All outputs are registered. Every strobe is high for exactly 1 cycle per event.
- **Previous-level registers.** One `prev_*` register per input, updated every cycle, including while `enable` is low.
- **Rising edge.** Defined as `lvl & ~prev`.
- **Reset.**
  - `prev_*` load 1, so a key held through reset does not fire until it is released and pressed again.
  - Every output is 0 and all FSMs are IDLE.
- **Horizontal FSM states.** IDLE, DAS, ARR; tracks `dir` (L or R) and counter `hcnt`.
- **IDLE:**
  - On a rising edge of left or right: emit a strobe for that direction, set `dir`, clear `hcnt`, go to DAS.
  - If both rise in the same cycle, left wins.
- **DAS:**
  - Increment `hcnt`.
  - When `hcnt` reaches `DAS_CYCLES-1`: emit a `dir` strobe, clear `hcnt`, go to ARR.
- **ARR:**
  - Increment `hcnt`.
  - When `hcnt` reaches `ARR_CYCLES-1`: emit a `dir` strobe and clear `hcnt`.
- **Direction changes in DAS or ARR:**
  - A rising edge of the opposite direction means last-pressed wins: switch `dir`, emit a strobe, clear `hcnt`, go to DAS.
  - If the active direction is released while the opposite is still held: switch `dir`, emit a strobe, clear `hcnt`, go to DAS.
  - If the active direction is released and nothing is held: go to IDLE with no strobe.
- **Soft drop** (IDLE/REP, counter `dcnt`):
  - A rising edge emits `key_down`, clears `dcnt`, and goes to REP.
  - In REP, `key_down` fires each time `dcnt` reaches `SOFT_CYCLES-1`.
  - Release returns to IDLE.
- **Rotate:**
  - Rising edge only.
  - If cw and ccw rise in the same cycle, only `key_rotate_cw` fires.
- **Hard drop and hold:** rising edge only; they are independent of each other and of all other keys.
- **`enable` low:**
  - All strobes and `key_drop_held` are 0.
  - Both FSMs are forced to IDLE and the counters are cleared.
  - Because `prev_*` keep tracking, a key held across `enable` rising does not fire.
- **Counter widths:** `$clog2(max(param)+1)` bits; counters never wrap past the terminal value.

## Timing
- **Edge-to-strobe latency.** A level first sampled high at edge t puts the strobe high in cycle t+1, for 1 cycle.
- **Left/right held from edge t.** Strobes at t+1, t+1+DAS, t+1+DAS+ARR, then every ARR cycles after that.
- **Down held from edge t.** Strobes at t+1, t+1+SOFT, t+1+2·SOFT, and so on.
- **Release.** A release sampled at edge t produces no strobe from t+1 onward. A strobe already registered at t still appears in cycle t only.
- **`key_drop_held`.** Follows `lvl_drop` with 1-cycle latency.
- **Reset.** `rst` sampled high at edge t clears all outputs in cycle t+1; this overrides any simultaneous edge.
- **Independence.** The horizontal, soft-drop and single-shot paths may all strobe in the same cycle.

## Test plan
Bench overrides: `DAS_CYCLES=4`, `ARR_CYCLES=2`, `SOFT_CYCLES=3`; `enable=1` unless noted.
- **Left DAS/ARR.** Hold `lvl_left` for 12 cycles from edge 0 → `key_left` strobes at cycles 1, 5, 7, 9, 11 and nothing after release. `key_right` stays 0.
- **Last-pressed wins.**
  - Hold left from edge 0 and add right at edge 6 → `key_right` at 7 and 11; `key_left` stops after 5.
  - Release right at edge 8 with left still held → `key_left` at 9 and 13.
- **Simultaneous edges.**
  - Left and right rise on the same edge → only `key_left`.
  - cw and ccw rise together → only `key_rotate_cw`.
  - Drop and hold rise together → both strobe, each for 1 cycle.
- **Soft drop and drop-held.**
  - Hold `lvl_down` from edge 0 for 8 cycles → `key_down` at 1, 4, 7.
  - Hold `lvl_drop` for 6 cycles → one `key_drop` at 1; `key_drop_held` high in cycles 1–6.
- **Reset and enable.**
  - `lvl_hold` held through `rst` deassertion → no `key_hold` until it is released and pressed again.
  - Left held across `enable` going 0→1 → no strobes.
  - `enable` dropped mid-ARR → strobes stop the next cycle and the FSM is IDLE.
